pdatapath_exec_ctrl: RTL and testbench

//  Execution sequencer for the single-cycle 8-bit datapath. Replaces direct pushbutton clocking:

---
 rtl/pdatapath_exec_ctrl_pkg.sv | 23 ++
 rtl/pdatapath_exec_ctrl_tick_gen.sv | 41 ++++
 rtl/pdatapath_exec_ctrl.sv | 135 +++++++++++++
 tb/tb_pdatapath_exec_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pdatapath_exec_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pdatapath_exec_ctrl_pkg
// Shared definitions for the datapath execution sequencer:
//   exec_state_e     sequencer state encoding (IDLE / RUN / HALTED)
//   HALT_OP_DEFAULT  opcode that stops free-run until reset
//   div_width()      counter width needed for a clock divider of a given ratio
// ---------------------------------------------------------------------------
package pdatapath_exec_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_HALTED = 2'b10
   } exec_state_e;

   localparam logic [3:0] HALT_OP_DEFAULT = 4'hF;

   // Width of a counter that must hold 0..div-1; never narrower than one bit.
   function automatic int unsigned div_width(input int unsigned div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/pdatapath_exec_ctrl_tick_gen.sv
// ---------------------------------------------------------------------------
// pdatapath_exec_ctrl_tick_gen
// Free-running prescaler for RUN mode. Counts 0..DIV-1 and wraps; tick is
// high while the count sits at DIV-1 (the terminal count).
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous reset, active-high
//   clear  in   synchronous clear; holds the count at 0 and masks tick
//   tick   out  terminal-count indication
// ---------------------------------------------------------------------------
module pdatapath_exec_ctrl_tick_gen
   import pdatapath_exec_ctrl_pkg::*;
#(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned W = div_width(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear || count == LAST) begin
         count <= '0;
      end else begin
         count <= count + W'(1);
      end
   end

   // Masking with clear keeps a stale terminal count from firing on the
   // same cycle RUN is being abandoned.
   assign tick = ~clear & (count == LAST);

endmodule

// File: rtl/pdatapath_exec_ctrl.sv
// ---------------------------------------------------------------------------
// pdatapath_exec_ctrl
// Execution sequencer for the single-cycle 8-bit datapath. The datapath runs
// on clk and commits an instruction only on cycles where adv_en is high.
// Supports pushbutton single-step, divided-rate free-run, a PC breakpoint and
// a halt opcode.
// Ports:
//   clk          in   system clock
//   rst_general  in   asynchronous reset, active-high
//   step_btn     in   debounced step button level (steps on rising edge)
//   run_sw       in   1 requests free-run
//   bp_en        in   breakpoint enable
//   bp_addr      in   breakpoint PC
//   pc           in   current PC
//   opcode       in   opcode of the current instruction
//   adv_en       out  one-cycle commit enable
//   state        out  00 IDLE, 01 RUN, 10 HALTED
//   halted       out  1 while HALTED
//   retired      out  number of adv_en pulses, saturating
// ---------------------------------------------------------------------------
module pdatapath_exec_ctrl
   import pdatapath_exec_ctrl_pkg::*;
#(
   parameter int unsigned PC_W    = 8,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned RUN_DIV = 25000000,
   parameter logic [3:0]  HALT_OP = HALT_OP_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_general,
   input  logic             step_btn,
   input  logic             run_sw,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic [PC_W-1:0]  pc,
   input  logic [3:0]       opcode,
   output logic             adv_en,
   output logic [1:0]       state,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   exec_state_e state_q, state_d;
   logic        step_q;
   logic        step_rise;
   logic        bp_skip_q, bp_skip_d;
   logic        bp_hit;
   logic        adv_d;
   logic        halted_d;
   logic        prescale_clear;
   logic        tick;

   assign step_rise = step_btn & ~step_q;

   // bp_skip suppresses the breakpoint for the first instruction after
   // entering RUN, so free-run can resume from the breakpoint PC itself.
   assign bp_hit = bp_en & (pc == bp_addr) & ~bp_skip_q;

   // The prescaler only runs while RUN is held; leaving RUN always restarts
   // the count so the first commit after re-entry is a full period away.
   assign prescale_clear = (state_q != ST_RUN) | ~run_sw;

   pdatapath_exec_ctrl_tick_gen #(
      .DIV (RUN_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst   (rst_general),
      .clear (prescale_clear),
      .tick  (tick)
   );

   // Next-state logic. Dropping run_sw beats a terminal count; at a terminal
   // count the halt opcode beats the breakpoint, which beats a commit.
   always_comb begin
      state_d   = state_q;
      bp_skip_d = bp_skip_q;
      adv_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run_sw) begin
               state_d   = ST_RUN;
               bp_skip_d = 1'b1;
            end else if (step_rise) begin
               adv_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (!run_sw) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               if (opcode == HALT_OP) begin
                  state_d = ST_HALTED;
               end else if (bp_hit) begin
                  state_d = ST_IDLE;
               end else begin
                  adv_d     = 1'b1;
                  bp_skip_d = 1'b0;
               end
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      halted_d = (state_d == ST_HALTED);
   end

   // State register and registered outputs; retired counts the pulses
   // already presented on adv_en and sticks at all-ones.
   always_ff @(posedge clk or posedge rst_general) begin
      if (rst_general) begin
         state_q   <= ST_IDLE;
         step_q    <= 1'b0;
         bp_skip_q <= 1'b0;
         adv_en    <= 1'b0;
         halted    <= 1'b0;
         retired   <= '0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_btn;
         bp_skip_q <= bp_skip_d;
         adv_en    <= adv_d;
         halted    <= halted_d;
         if (adv_en && retired != '1) begin
            retired <= retired + CNT_W'(1);
         end
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_pdatapath_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pdatapath_exec_ctrl
// Self-checking bench for pdatapath_exec_ctrl with RUN_DIV=4. A second
// instance with a 3-bit retired counter shares every input so counter
// saturation is reached within a short run.
// ---------------------------------------------------------------------------
module tb_pdatapath_exec_ctrl;

   localparam int RUN_DIV = 4;
   localparam int CNT_W   = 16;
   localparam int SMALL_W = 3;

   logic        clk = 1'b0;
   logic        rst_general;
   logic        step_btn;
   logic        run_sw;
   logic        bp_en;
   logic [7:0]  bp_addr;
   logic [7:0]  pc;
   logic [3:0]  opcode;

   logic               adv_en;
   logic [1:0]         state;
   logic               halted;
   logic [CNT_W-1:0]   retired;
   logic               advS;
   logic [1:0]         stateS;
   logic               haltedS;
   logic [SMALL_W-1:0] retiredS;

   int total = 0;
   int bad   = 0;

   // Reference model: mode 0 idle, 1 run, 2 halted. Run-mode commits fall
   // on edges a whole number of RUN_DIV periods after the entry edge.
   int mMode;
   int mEdge;
   int mRunStart;
   int mAdvTotal;
   bit mSkip;
   bit mStepPrev;
   bit mAdv;

   int curPc;
   bit pendingInc;

   pdatapath_exec_ctrl #(
      .PC_W(8), .CNT_W(CNT_W), .RUN_DIV(RUN_DIV), .HALT_OP(4'hF)
   ) dut (
      .clk(clk), .rst_general(rst_general), .step_btn(step_btn), .run_sw(run_sw),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .opcode(opcode),
      .adv_en(adv_en), .state(state), .halted(halted), .retired(retired)
   );

   pdatapath_exec_ctrl #(
      .PC_W(8), .CNT_W(SMALL_W), .RUN_DIV(RUN_DIV), .HALT_OP(4'hF)
   ) dutSmall (
      .clk(clk), .rst_general(rst_general), .step_btn(step_btn), .run_sw(run_sw),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .opcode(opcode),
      .adv_en(advS), .state(stateS), .halted(haltedS), .retired(retiredS)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic modelReset();
      mMode     = 0;
      mEdge     = 0;
      mRunStart = 0;
      mAdvTotal = 0;
      mSkip     = 1'b0;
      mStepPrev = 1'b0;
      mAdv      = 1'b0;
   endtask

   // Advance the model across one rising edge using the inputs now driven.
   task automatic modelEdge();
      bit rise;
      bit newAdv;
      rise   = step_btn && !mStepPrev;
      newAdv = 1'b0;
      mEdge++;
      if (mAdv) mAdvTotal++;
      case (mMode)
         0: begin
            if (run_sw) begin
               mMode     = 1;
               mRunStart = mEdge;
               mSkip     = 1'b1;
            end else if (rise) begin
               newAdv = 1'b1;
            end
         end
         1: begin
            if (!run_sw) begin
               mMode = 0;
            end else if ((mEdge - mRunStart) % RUN_DIV == 0) begin
               if (opcode == 4'hF) begin
                  mMode = 2;
               end else if (bp_en && pc == bp_addr && !mSkip) begin
                  mMode = 0;
               end else begin
                  newAdv = 1'b1;
                  mSkip  = 1'b0;
               end
            end
         end
         default: ;
      endcase
      mStepPrev = step_btn;
      mAdv      = newAdv;
   endtask

   task automatic checkVal(input string tag, input string name,
                           input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s/%s observed=%0h expected=%0h", tag, name, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [1:0] expState;
      int expRet;
      int expRetS;
      expState = (mMode == 0) ? 2'b00 : (mMode == 1) ? 2'b01 : 2'b10;
      expRet   = (mAdvTotal > 65535) ? 65535 : mAdvTotal;
      expRetS  = (mAdvTotal > 7) ? 7 : mAdvTotal;
      checkVal(tag, "adv_en",   32'(adv_en),   32'(mAdv));
      checkVal(tag, "state",    32'(state),    32'(expState));
      checkVal(tag, "halted",   32'(halted),   32'(mMode == 2));
      checkVal(tag, "retired",  32'(retired),  32'(expRet));
      checkVal(tag, "adv_en_s", 32'(advS),     32'(mAdv));
      checkVal(tag, "state_s",  32'(stateS),   32'(expState));
      checkVal(tag, "halted_s", 32'(haltedS),  32'(mMode == 2));
      checkVal(tag, "retired_s",32'(retiredS), 32'(expRetS));
   endtask

   // Drive one cycle of inputs, step the model, then check after the edge.
   task automatic applyStimulus(input bit step, input bit run, input bit be,
                                input logic [7:0] ba, input logic [7:0] pcv,
                                input logic [3:0] op, input string tag);
      step_btn = step;
      run_sw   = run;
      bp_en    = be;
      bp_addr  = ba;
      pc       = pcv;
      opcode   = op;
      modelEdge();
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   // PC follows commits: adv_en high in a cycle moves PC at the next edge.
   task automatic pcCycle(input bit run, input string tag);
      applyStimulus(1'b0, run, 1'b1, 8'd2, 8'(curPc), 4'($urandom_range(0, 14)), tag);
      if (pendingInc) curPc++;
      pendingInc = mAdv;
   endtask

   initial begin
      rst_general = 1'b1;
      step_btn = 1'b0; run_sw = 1'b0; bp_en = 1'b0;
      bp_addr = '0; pc = '0; opcode = '0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset");
      @(negedge clk);
      rst_general = 1'b0;

      $display("[TB] single step with button held");
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0, "step_hold");
      for (int i = 0; i < 3; i++)  applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0, "step_release");

      $display("[TB] random steps overriding breakpoint and halt opcode");
      for (int i = 0; i < 30; i++)
         applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b1, 8'h05, 8'h05, 4'hF, "step_override");

      $display("[TB] async reset mid-run");
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 4'd1, "run_enter");
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 4'd1, "run_cnt1");
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 4'd1, "run_cnt2");
      #1 rst_general = 1'b1;
      modelReset();
      #1 checkOutput("async_rst");
      @(negedge clk);
      rst_general = 1'b0;
      step_btn = 1'b0;

      $display("[TB] run and step rise on the same edge");
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0, "idle_pre");
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 4'd0, "run_step_same");
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0, "run_stop");

      $display("[TB] breakpoint at pc=2 and resume");
      curPc = 0;
      pendingInc = 1'b0;
      for (int i = 0; i < 30; i++) begin
         pcCycle(1'b1, "bp_run");
         if (i > 0 && mMode == 0) break;
      end
      for (int i = 0; i < 2; i++)  pcCycle(1'b0, "bp_off");
      for (int i = 0; i < 12; i++) pcCycle(1'b1, "bp_resume");

      $display("[TB] long free-run to saturate the narrow counter");
      for (int i = 0; i < 40; i++)
         applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b0, 8'd0,
                       8'($urandom), 4'($urandom_range(0, 14)), "free_run");

      $display("[TB] random mix of run, step and breakpoint");
      for (int i = 0; i < 150; i++) begin
         bit runNext;
         runNext = ($urandom_range(0, 7) == 0) ? !run_sw : run_sw;
         applyStimulus(1'($urandom_range(0, 1)), runNext, 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                       4'($urandom_range(0, 14)), "random_mix");
      end

      $display("[TB] halt opcode in run");
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0, "halt_pre");
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 4'd3, "halt_run");
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 4'hF, "halt_op");
      for (int i = 0; i < 20; i++)
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 8'd0,
                       8'd0, 4'($urandom_range(0, 15)), "halted_ignore");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
